xeng_tap_sequencer: RTL
=======================

// Module: xeng_tap_sequencer
// PURPOSE
//  Sequences the X-engine baseline-tap chain. Pulls whole integration windows from an upstream buffer and
//  streams them into the chain. Each window is N_ANTS*2^SERIAL_ACC_LEN_BITS words. The block drives the
//  chain's rst/sync strobe at each window start, tracks the antenna index, and reports underruns and a
//  window count.
//  The chain cannot stall, so once a window starts it always runs to completion.
// PARAMETERS
//  SERIAL_ACC_LEN_BITS  7   log2 serial accumulation length (words per antenna slot)
//  N_ANTS               8   dual-pol antennas per window (power of 2, >=2)
//  INPUT_WIDTH          16  width of one dual-pol antenna word (2*BITWIDTH*2*P_FACTOR)
//  WIN_CNT_WIDTH        32  width of completed-window counter
// PORTS
//  clk          in   1              clock
//  rst          in   1              reset, synchronous, active-high
//  sync_in      in   1              system sync; arms/re-arms sequencer
//  frame_avail  in   1              upstream holds >= one full window
//  din          in   INPUT_WIDTH    upstream antenna word
//  din_valid    in   1              din valid
//  din_ready    out  1              sequencer consuming din this cycle
//  tap_a        out  INPUT_WIDTH    word to chain a_del/a_ndel/a_end inputs
//  tap_rst      out  1              1-cycle strobe at first word of each window (chain rst)
//  tap_sync     out  1              sync_in delayed 1 cycle (chain sync1)
//  tap_ant      out  log2(N_ANTS)   antenna index of word on tap_a
//  busy         out  1              window in progress on tap_a
//  underrun     out  1              sticky: din_valid low while din_ready high
//  clr_err      in   1              clears underrun (1-cycle pulse)
//  win_cnt      out  WIN_CNT_WIDTH  completed windows, wraps
// BEHAVIOUR
//  W = N_ANTS<<SERIAL_ACC_LEN_BITS. Counter pos[log2(W)-1:0]; tap_ant = pos[MSBs].
//  Reset: state IDLE. Outputs tap_a=0, tap_rst=0, tap_sync=0, tap_ant=0, busy=0, din_ready=0,
//   underrun=0, win_cnt=0.
//  States:
//   IDLE  -> ARMED  on sync_in.
//   ARMED -> RUN    when frame_avail=1 && !sync_in; pos<=0.
//   RUN   - din_ready=1 for exactly W consecutive cycles.
//         - on last cycle (pos==W-1): win_cnt++.
//         - then RUN again (back-to-back, no gap) if frame_avail && !resync_pend.
//         - else ARMED; resync_pend cleared.
//  din_ready is combinational from state (RUN). Upstream must not rely on it to decide din_valid.
//  Pipeline: tap_a, tap_ant, tap_rst, busy are registered, 1 cycle after the din_ready cycle.
//   tap_rst=1 alongside word pos==0. busy=1 for the W output cycles.
//   Between windows: tap_a holds 0, busy=0.
//  Underrun: din_ready && !din_valid -> that slot's tap_a=0, underrun<=1. pos still advances and window
//   length is unchanged.
//  Underrun priority: clr_err and a new underrun in the same cycle -> underrun=1 (set wins).
//  sync_in during RUN: resync_pend<=1. The window completes unchanged, and the next window only starts
//   after ARMED is re-entered.
//  sync_in in ARMED: stays ARMED that cycle (no start same cycle as sync).
//  tap_sync = sync_in registered, independent of state.
//  rst mid-window: abort immediately, IDLE. No tap_rst emitted. win_cnt=0. Partial window discarded.
//  win_cnt wraps 2^WIN_CNT_WIDTH-1 -> 0 silently.
// TESTING (N_ANTS=4, SERIAL_ACC_LEN_BITS=2, W=16, INPUT_WIDTH=16)
//  T1: rst, sync_in pulse, frame_avail=1, din=incrementing 0x0000.. valid
//      -> first din_ready 2 cycles after sync.
//      -> tap_rst with tap_a=0x0000, tap_ant=0,0,0,0,1..3.
//      -> win_cnt=1 after 16 words.
//  T2: frame_avail held 1 for 3 windows -> 48 contiguous din_ready cycles.
//      -> tap_rst every 16 cycles, win_cnt=3, busy never drops.
//  T3: din_valid=0 at pos 5 -> tap_a=0 at that slot, underrun=1, window still 16 words.
//      -> clr_err pulse -> underrun=0.
//  T4: sync_in at pos 8 -> window ends at pos 15, state ARMED, 1-cycle gap, next window starts
//      with tap_rst.
//  T5: rst asserted at pos 10 -> next cycle din_ready=0, busy=0, win_cnt=0.
//      -> no activity until next sync_in.
//  T6: force win_cnt=0xFFFFFFFF, complete one window -> win_cnt=0.

Source files
------------

// File: rtl/xeng_tap_sequencer.sv
// X-engine tap-chain sequencer: pulls whole integration windows from upstream and
// streams them into the baseline-tap chain with a per-window rst strobe and antenna index.
module xeng_tap_sequencer #(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int N_ANTS              = 8,
    parameter int INPUT_WIDTH         = 16,
    parameter int WIN_CNT_WIDTH       = 32,
    localparam int ANT_BITS           = $clog2(N_ANTS),
    localparam int POS_BITS           = ANT_BITS + SERIAL_ACC_LEN_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync_in,
    input  logic                     frame_avail,
    input  logic [INPUT_WIDTH-1:0]   din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [INPUT_WIDTH-1:0]   tap_a,
    output logic                     tap_rst,
    output logic                     tap_sync,
    output logic [ANT_BITS-1:0]      tap_ant,
    output logic                     busy,
    output logic                     underrun,
    input  logic                     clr_err,
    output logic [WIN_CNT_WIDTH-1:0] win_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t              state_q, state_d;
    logic [POS_BITS-1:0] pos_q;
    logic                resync_pend_q;
    logic                last;

    assign last      = (pos_q == {POS_BITS{1'b1}});
    assign din_ready = (state_q == RUN);

    // A sync seen on the final word also blocks the back-to-back restart.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sync_in) state_d = ARMED;
            ARMED:   if (frame_avail && !sync_in) state_d = RUN;
            RUN:     if (last && !(frame_avail && !resync_pend_q && !sync_in)) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pos_q         <= '0;
            resync_pend_q <= 1'b0;
            win_cnt       <= '0;
            underrun      <= 1'b0;
            tap_sync      <= 1'b0;
            tap_a         <= '0;
            tap_rst       <= 1'b0;
            tap_ant       <= '0;
            busy          <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_sync <= sync_in;

            // pos wraps to 0 on the last word, so back-to-back windows need no reload.
            if (din_ready) pos_q <= pos_q + POS_BITS'(1);
            else           pos_q <= '0;

            if (!din_ready || last) resync_pend_q <= 1'b0;
            else if (sync_in)       resync_pend_q <= 1'b1;

            if (din_ready && last) win_cnt <= win_cnt + WIN_CNT_WIDTH'(1);

            if (din_ready && !din_valid) underrun <= 1'b1;
            else if (clr_err)            underrun <= 1'b0;

            busy    <= din_ready;
            tap_rst <= din_ready && (pos_q == '0);
            tap_ant <= din_ready ? pos_q[POS_BITS-1 -: ANT_BITS] : '0;
            tap_a   <= (din_ready && din_valid) ? din : '0;
        end
    end

endmodule
